// File: rtl/seg_display_pkg.sv
// Shared constants for the CPU seven-segment output stage: source-select codes and the
// active-low hex-to-segment table, with bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

    localparam logic [1:0] MODE_F   = 2'd0;
    localparam logic [1:0] MODE_MEM = 2'd1;
    localparam logic [1:0] MODE_PC  = 2'd2;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: a 2-flop synchronizer feeds a stability counter, and an
// accepted rising level emits a single-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [1:0]      sync_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;
    logic            press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            press_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                press_q <= sync_q[1];  // release is accepted silently
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_seg_display.sv
// Board output stage: snapshots CPU F/Mem/PC/flags, lets buttons pick the source and
// freeze it, and scans the chosen word across eight multiplexed hex digits.
module cpu_seg_display #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] F,
    input  logic [31:0] Mem,
    input  logic [31:0] PC,
    input  logic        ZF,
    input  logic        OF,
    input  logic        sel_btn,
    input  logic        frz_btn,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  led,
    output logic [1:0]  mode
);

    import seg_display_pkg::*;

    localparam int unsigned    DivW   = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

    logic sel_press;
    logic frz_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (sel_btn),
        .press   (sel_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_frz_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (frz_btn),
        .press   (frz_press)
    );

    logic [1:0]      mode_q, mode_d;
    logic            frozen_q, frozen_d;
    logic [31:0]     snap_f_q, snap_mem_q, snap_pc_q;
    logic [1:0]      snap_flags_q;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic [31:0]     word;
    logic [3:0]      nibble;

    always_comb begin
        mode_d = mode_q;
        if (sel_press) begin
            mode_d = (mode_q == MODE_PC) ? MODE_F : mode_q + 2'd1;
        end
        frozen_d = frozen_q ^ frz_press;

        div_d = div_q + DivW'(1);
        idx_d = idx_q;
        if (div_q == DivMax) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end

        unique case (mode_q)
            MODE_MEM: word = snap_mem_q;
            MODE_PC:  word = snap_pc_q;
            default:  word = snap_f_q;
        endcase
        nibble = word[{idx_q, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_F;
            frozen_q     <= 1'b0;
            snap_f_q     <= '0;
            snap_mem_q   <= '0;
            snap_pc_q    <= '0;
            snap_flags_q <= 2'b00;
            div_q        <= '0;
            idx_q        <= 3'd0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            frozen_q <= frozen_d;
            // Old frozen_q gates the load, so the freeze cycle itself still captures.
            if (!frozen_q) begin
                snap_f_q     <= F;
                snap_mem_q   <= Mem;
                snap_pc_q    <= PC;
                snap_flags_q <= {OF, ZF};
            end
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= ~(8'h01 << idx_q);
            seg_q <= hex2seg(nibble);
            dp_q  <= !((idx_q == 3'd0) && frozen_q);
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign led  = snap_flags_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_cpu_seg_display.sv
// Directed self-checking bench for cpu_seg_display with SCAN_DIV=4, DEBOUNCE_CYCLES=3.
module tb_cpu_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] F = '0, Mem = '0, PC = '0;
    logic        ZF = 1'b0, OF = 1'b0;
    logic        sel_btn = 1'b0, frz_btn = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  led;
    logic [1:0]  mode;

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_seg_display #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .F       (F),
        .Mem     (Mem),
        .PC      (PC),
        .ZF      (ZF),
        .OF      (OF),
        .sel_btn (sel_btn),
        .frz_btn (frz_btn),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .led     (led),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] tb_hex(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_btns(input logic s, input logic f);
        @(negedge clk);
        sel_btn = s;
        frz_btn = f;
        repeat (8) @(negedge clk);
        sel_btn = 1'b0;
        frz_btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Returns on the first sample of a digit-0 window.
    task automatic sync_digit0(output logic ok);
        logic seen7f;
        seen7f = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (seen7f && an === 8'hFE) begin
                ok = 1'b1;
                break;
            end
            if (an === 8'h7F) seen7f = 1'b1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            F = $urandom;
            Mem = $urandom;
            PC = $urandom;
            ZF = ~ZF;
            OF = ~OF;
            sel_btn = ~sel_btn;
            frz_btn = ~frz_btn;
        end
        @(negedge clk);
        tests_run++;
        if (an !== 8'hFF) begin tests_failed++; $display("FAIL reset_an: got %h want ff", an); end
        tests_run++;
        if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        tests_run++;
        if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b want 1", dp); end
        tests_run++;
        if (mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d want 0", mode); end
        tests_run++;
        if (led !== 2'b00) begin tests_failed++; $display("FAIL reset_led: got %b want 00", led); end
        F = '0; Mem = '0; PC = '0; ZF = 1'b0; OF = 1'b0;
        sel_btn = 1'b0; frz_btn = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (an !== 8'hFE) begin tests_failed++; $display("FAIL reset_exit_an: got %h want fe", an); end
        tests_run++;
        if (seg !== 7'b1000000) begin
            tests_failed++; $display("FAIL reset_exit_seg: got %b want 1000000", seg);
        end
    endtask

    task automatic test_scan;
        logic [7:0] exp_an;
        int k;
        F = 32'h89ABCDEF;
        apply_reset();
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            k = s / 4;
            exp_an = ~(8'h01 << k);
            tests_run++;
            if (an !== exp_an) begin
                tests_failed++; $display("FAIL scan_an[%0d]: got %h want %h", s, an, exp_an);
            end
            if (s % 4 == 3) begin
                tests_run++;
                if (seg !== tb_hex(F[4*k +: 4])) begin
                    tests_failed++;
                    $display("FAIL scan_seg[%0d]: got %b want %b", k, seg, tb_hex(F[4*k +: 4]));
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (an !== 8'hFE) begin tests_failed++; $display("FAIL scan_wrap_an: got %h want fe", an); end
    endtask

    task automatic test_debounce;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (mode !== 2'd0) begin
                tests_failed++; $display("FAIL bounce_mode[%0d]: got %0d want 0", i, mode);
            end
            sel_btn = (i % 2 == 0);
        end
        @(negedge clk);
        sel_btn = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            tests_run++;
            if (mode !== 2'd0) begin
                tests_failed++; $display("FAIL debounce_early[%0d]: got %0d want 0", j, mode);
            end
        end
        @(negedge clk);
        tests_run++;
        if (mode !== 2'd1) begin tests_failed++; $display("FAIL debounce_step: got %0d want 1", mode); end
        repeat (10) @(negedge clk);
        tests_run++;
        if (mode !== 2'd1) begin tests_failed++; $display("FAIL debounce_hold: got %0d want 1", mode); end
        sel_btn = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++; $display("FAIL debounce_release: got %0d want 1", mode);
        end
    endtask

    task automatic test_mode_wrap;
        logic ok;
        logic [6:0] exp_seg [4];
        logic [1:0] exp_mode [4];
        exp_seg[0] = 7'b1111001; exp_mode[0] = 2'd0;
        exp_seg[1] = 7'b0100100; exp_mode[1] = 2'd1;
        exp_seg[2] = 7'b0110000; exp_mode[2] = 2'd2;
        exp_seg[3] = 7'b1111001; exp_mode[3] = 2'd0;
        F = 32'd1; Mem = 32'd2; PC = 32'd3;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            if (p > 0) press_btns(1'b1, 1'b0);
            sync_digit0(ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("FAIL wrap_sync[%0d]: got timeout want digit0", p); end
            tests_run++;
            if (mode !== exp_mode[p]) begin
                tests_failed++; $display("FAIL wrap_mode[%0d]: got %0d want %0d", p, mode, exp_mode[p]);
            end
            tests_run++;
            if (seg !== exp_seg[p]) begin
                tests_failed++; $display("FAIL wrap_seg[%0d]: got %b want %b", p, seg, exp_seg[p]);
            end
        end
    endtask

    task automatic test_freeze;
        logic ok;
        logic [31:0] word;
        logic [1:0]  exp_led;
        logic        frz;
        F = 32'h12345678; ZF = 1'b0; OF = 1'b0;
        repeat (2) @(negedge clk);
        press_btns(1'b0, 1'b1);
        F = 32'h0; ZF = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) press_btns(1'b0, 1'b1);
            word    = (pass == 0) ? 32'h12345678 : 32'h0;
            exp_led = (pass == 0) ? 2'b00 : 2'b01;
            frz     = (pass == 0);
            sync_digit0(ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("FAIL frz_sync[%0d]: got timeout want digit0", pass); end
            for (int k = 0; k < 8; k++) begin
                if (k > 0) repeat (4) @(negedge clk);
                tests_run++;
                if (seg !== tb_hex(word[4*k +: 4])) begin
                    tests_failed++;
                    $display("FAIL frz_seg[%0d][%0d]: got %b want %b", pass, k, seg,
                             tb_hex(word[4*k +: 4]));
                end
                tests_run++;
                if (dp !== !(frz && k == 0)) begin
                    tests_failed++;
                    $display("FAIL frz_dp[%0d][%0d]: got %b want %b", pass, k, dp, !(frz && k == 0));
                end
            end
            tests_run++;
            if (led !== exp_led) begin
                tests_failed++; $display("FAIL frz_led[%0d]: got %b want %b", pass, led, exp_led);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic ok;
        Mem = 32'h0000000A;
        repeat (2) @(negedge clk);
        press_btns(1'b1, 1'b1);
        Mem = 32'h0000000F;
        tests_run++;
        if (mode !== 2'd1) begin tests_failed++; $display("FAIL simul_mode: got %0d want 1", mode); end
        sync_digit0(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL simul_sync: got timeout want digit0"); end
        tests_run++;
        if (dp !== 1'b0) begin tests_failed++; $display("FAIL simul_dp: got %b want 0", dp); end
        tests_run++;
        if (seg !== 7'b0001000) begin
            tests_failed++; $display("FAIL simul_seg: got %b want 0001000", seg);
        end
    endtask

    task automatic test_async_reset;
        repeat (5) @(negedge clk);
        sel_btn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (an !== 8'hFF) begin tests_failed++; $display("FAIL async_an: got %h want ff", an); end
        tests_run++;
        if (seg !== 7'h7F) begin tests_failed++; $display("FAIL async_seg: got %b want 1111111", seg); end
        tests_run++;
        if (dp !== 1'b1) begin tests_failed++; $display("FAIL async_dp: got %b want 1", dp); end
        tests_run++;
        if (mode !== 2'd0) begin tests_failed++; $display("FAIL async_mode: got %0d want 0", mode); end
        tests_run++;
        if (led !== 2'b00) begin tests_failed++; $display("FAIL async_led: got %b want 00", led); end
        @(negedge clk);
        sel_btn = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (an !== 8'hFE) begin tests_failed++; $display("FAIL async_exit_an: got %h want fe", an); end
        repeat (10) @(negedge clk);
        tests_run++;
        if (mode !== 2'd0) begin
            tests_failed++; $display("FAIL async_no_press: got %0d want 0", mode);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_debounce();
        test_mode_wrap();
        test_freeze();
        test_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_seg_display.md
# cpu_seg_display

Board-level output stage downstream of the multi-cycle CPU: consumes the CPU's `F`, `Mem`, `PC`, `ZF` and `OF` outputs and presents one selected 32-bit value as eight hex digits on a time-multiplexed 7-segment display. The condition flags go to two LEDs. Two push-buttons are debounced in-block: one cycles the displayed source, the other freezes a snapshot for stepping through a program run.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit (≥2).
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized button level must hold stable before it is accepted (≥1).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `F`  in  32  CPU ALU result.
- `Mem`  in  32  CPU memory data.
- `PC`  in  32  CPU program counter.
- `ZF`  in  1  CPU zero flag.
- `OF`  in  1  CPU overflow flag.
- `sel_btn`  in  1  raw, asynchronous, bouncy push-button; cycles the source.
- `frz_btn`  in  1  raw, asynchronous, bouncy push-button; toggles freeze.
- `an`  out  8  digit enables, active-low; `an[k]` is hex digit k, digit 0 least significant.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `led`  out  2  {OF, ZF}, active-high.
- `mode`  out  2  current source: 0=F, 1=Mem, 2=PC.

## Operation
- **Debounce, per button.**
  - 2-flop synchronizer feeds a stability counter.
  - Counter resets whenever the synchronized level differs from the accepted level.
  - When the counter reaches `DEBOUNCE_CYCLES`, the accepted level takes the new value.
  - An accepted 0→1 transition produces a one-cycle `press` pulse. Release produces no pulse.
- **Mode.**
  - Each `sel` press advances the mode F→Mem→PC→F.
  - Value 3 is never reached.
- **Freeze.**
  - Each `frz` press toggles `frozen`.
  - While `frozen`=0, the snapshot registers `snap_F`, `snap_Mem`, `snap_PC`, `snap_flags` load their inputs every cycle.
  - While `frozen`=1, all four snapshot registers hold.
  - Changing mode while frozen shows the frozen copy of the newly selected source.
- **Scan.**
  - A divider counts 0..`SCAN_DIV`-1.
  - On wrap, digit index `idx` (3 bits) increments modulo 8 (7→0).
  - Displayed word = snapshot selected by `mode`.
  - `nibble` = word[4·idx+3 : 4·idx].
- **Outputs.**
  - `an` = ~(1<<idx).
  - `seg` = hex decode of `nibble`. Examples: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
  - `dp` = 0 only when idx=0 and `frozen`=1; otherwise 1.
  - `led` = `snap_flags`.
- **Simultaneous presses.** `sel` and `frz` pulses in the same cycle both take effect in that cycle.

## Timing
- **Registers.** All outputs are registered. `an`, `seg` and `dp` change together, one cycle after `idx` changes.
- **Reset values.**
  - Outputs: `an`=FF, `seg`=1111111, `dp`=1, `led`=00, `mode`=0.
  - Internal state: `frozen`=0, `idx`=0, divider=0, debouncers in the released state, snapshots=0.
- **Asserting `rst` mid-scan or mid-debounce.** Forces the reset values immediately, without waiting for a clock edge.
- **Reset exit.** The first digit (idx 0) is driven on the first clock edge after reset deasserts.
- **Button latency.** From a clean raw edge to the `press` pulse: 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles. `mode`/`frozen` update on the cycle after the pulse.
- **Snapshot latency.** With `frozen`=0, a CPU input change appears in the snapshot 1 cycle later. It appears on the display the next time its digit is scanned, plus 1 cycle.
- **Freeze edge.** The value captured is the input present in the cycle the `frz` pulse is seen.

## Structure
- **Package `seg_display_pkg`.**
  - Mode constants `MODE_F`, `MODE_MEM`, `MODE_PC`.
  - The 16-entry hex-to-segment constant table.
  - The function `hex2seg`.
- **Sub-module `btn_debounce`.**
  - Ports: `clk`, `rst`, `btn_raw`, `press`.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Instantiated twice.
- **Top level.** Holds the mode/freeze state, the snapshot registers, the scan divider and the output registers.

## Test plan
Benches use `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=3.
1. **Reset.** Hold `rst`, toggle inputs → `an`=FF, `seg`=7F, `dp`=1, `mode`=0. Release → `an`=FE within 1 cycle.
2. **Scan.** F=0x89ABCDEF, mode 0 → digits 0..7 show F,E,D,C,B,A,9,8. Each digit is lit 4 cycles. `an` walks FE→FD→…→7F→FE.
3. **Debounce.** `sel_btn` bounces 0/1 every cycle for 10 cycles, then holds 1 → exactly one mode step, 0→1, at 2+3+1 cycles after the last bounce.
4. **Mode wrap.** Three clean `sel` presses with F=1, Mem=2, PC=3 → digit 0 shows 1→2→3→1 (`seg` 1111001, 0100100, 0110000, 1111001).
5. **Freeze.** F=0x12345678, press `frz`, then change F to 0 and ZF to 1 → display still 12345678, `led` unchanged, `dp`=0 on digit 0. Press `frz` again → display 00000000, `led`[0]=1.
6. **Simultaneous and async reset.** `sel` and `frz` pulse in the same cycle → `mode`+1 and `frozen` toggles. Assert `rst` between clock edges mid-scan → outputs reach reset values before the next edge.
